// File: rtl/stream_run_seq_pkg.sv
// Shared types and default sizing for the stream run sequencer.
// The state encoding lives here so the top and any debug tooling agree on it.
package stream_run_seq_pkg;

    localparam int unsigned DEF_RUN_COUNT_WIDTH  = 16;
    localparam int unsigned DEF_BEAT_COUNT_WIDTH = 32;
    localparam int unsigned DEF_TIMEOUT_CYCLES   = 65536;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_WAIT   = 3'd2,
        ST_GAP    = 3'd3,
        ST_DONE   = 3'd4
    } seq_state_t;

    // Watchdog width: just wide enough to reach cycles-1, never narrower than one bit.
    function automatic int unsigned wd_width(input int unsigned cycles);
        return (cycles > 2) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/seq_sat_counter.sv
// Up-counter with synchronous clear, enable, saturation at all-ones and a
// terminal-compare flag against a caller-supplied value.
module seq_sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] term,
    output logic [WIDTH-1:0] count,
    output logic             at_max,
    output logic             at_term
);

    assign at_max  = &count;
    assign at_term = (count == term);

    always_ff @(posedge aclk) begin
        if (areset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && !at_max) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/stream_run_sequencer.sv
// Launches the stream generator num_runs times per host start, counts monitored
// beats, and guards each run with a watchdog.
//
// state   | meaning
// IDLE    | waiting for host ap_start; ap_idle high
// LAUNCH  | gen_start high for one cycle, watchdog cleared
// WAIT    | generator running; watchdog counting until gen_done or expiry
// GAP     | one low cycle so the next launch sees a fresh rising edge
// DONE    | ap_done pulse, counters hold for the host to read
module stream_run_sequencer
    import stream_run_seq_pkg::*;
#(
    parameter int unsigned C_RUN_COUNT_WIDTH  = DEF_RUN_COUNT_WIDTH,
    parameter int unsigned C_BEAT_COUNT_WIDTH = DEF_BEAT_COUNT_WIDTH,
    parameter int unsigned C_TIMEOUT_CYCLES   = DEF_TIMEOUT_CYCLES
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic                          ap_start,
    output logic                          ap_ready,
    output logic                          ap_idle,
    output logic                          ap_done,
    input  logic [C_RUN_COUNT_WIDTH-1:0]  num_runs,
    output logic                          gen_start,
    input  logic                          gen_done,
    input  logic                          s_mon_tvalid,
    input  logic                          s_mon_tready,
    output logic [C_RUN_COUNT_WIDTH-1:0]  runs_completed,
    output logic [C_BEAT_COUNT_WIDTH-1:0] beat_count,
    output logic                          err_timeout,
    output logic                          err_spurious
);

    localparam int unsigned RW   = C_RUN_COUNT_WIDTH;
    localparam int unsigned BW   = C_BEAT_COUNT_WIDTH;
    localparam int unsigned WD_W = wd_width(C_TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_TERM =
        (C_TIMEOUT_CYCLES == 0) ? '0 : WD_W'(C_TIMEOUT_CYCLES - 1);
    localparam bit WD_ENABLE = (C_TIMEOUT_CYCLES != 0);

    seq_state_t    state;
    logic [RW-1:0] target;
    logic [RW-1:0] run_term;
    logic          accept;
    logic          busy;
    logic          run_clr;
    logic          run_en;
    logic          run_last;
    logic          beat_en;
    logic          wd_clr;
    logic          wd_en;
    logic          wd_expired;
    logic          timeout_hit;
    logic [WD_W-1:0] wd_count_unused;
    logic          run_max_unused;
    logic          beat_max_unused;
    logic          beat_term_unused;
    logic          wd_max_unused;

    assign accept   = (state == ST_IDLE) && ap_start;
    assign ap_ready = accept;
    assign ap_idle  = (state == ST_IDLE);
    assign ap_done  = (state == ST_DONE);

    assign busy        = (state == ST_LAUNCH) || (state == ST_WAIT) || (state == ST_GAP);
    assign run_clr     = accept;
    assign run_en      = (state == ST_WAIT) && gen_done;
    // Last run when the count before this gen_done is target-1; target is nonzero here.
    assign run_term    = target - RW'(1);
    assign beat_en     = busy && s_mon_tvalid && s_mon_tready;
    assign wd_clr      = (state == ST_LAUNCH);
    assign wd_en       = (state == ST_WAIT);
    assign timeout_hit = WD_ENABLE && (state == ST_WAIT) && wd_expired && !gen_done;

    seq_sat_counter #(.WIDTH(RW)) u_run_cnt (
        .aclk    (aclk),
        .areset  (areset),
        .clr     (run_clr),
        .en      (run_en),
        .term    (run_term),
        .count   (runs_completed),
        .at_max  (run_max_unused),
        .at_term (run_last)
    );

    seq_sat_counter #(.WIDTH(BW)) u_beat_cnt (
        .aclk    (aclk),
        .areset  (areset),
        .clr     (accept),
        .en      (beat_en),
        .term    ({BW{1'b1}}),
        .count   (beat_count),
        .at_max  (beat_max_unused),
        .at_term (beat_term_unused)
    );

    seq_sat_counter #(.WIDTH(WD_W)) u_wd_cnt (
        .aclk    (aclk),
        .areset  (areset),
        .clr     (wd_clr),
        .en      (wd_en),
        .term    (WD_TERM),
        .count   (wd_count_unused),
        .at_max  (wd_max_unused),
        .at_term (wd_expired)
    );

    always_ff @(posedge aclk) begin
        if (areset) begin
            state        <= ST_IDLE;
            target       <= '0;
            gen_start    <= 1'b0;
            err_timeout  <= 1'b0;
            err_spurious <= 1'b0;
        end else begin
            gen_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (ap_start) begin
                        target       <= num_runs;
                        err_timeout  <= 1'b0;
                        err_spurious <= 1'b0;
                        if (num_runs == '0) begin
                            state <= ST_DONE;
                        end else begin
                            state     <= ST_LAUNCH;
                            gen_start <= 1'b1;
                        end
                    end
                end
                ST_LAUNCH: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (gen_done) begin
                        state <= run_last ? ST_DONE : ST_GAP;
                    end else if (timeout_hit) begin
                        err_timeout <= 1'b1;
                        state       <= ST_DONE;
                    end
                end
                ST_GAP: begin
                    state     <= ST_LAUNCH;
                    gen_start <= 1'b1;
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
            // A stray gen_done on the accept cycle is still reported.
            if (gen_done && (state != ST_WAIT)) begin
                err_spurious <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_stream_run_sequencer.sv
// Bench for stream_run_sequencer: acts as host and generator, predicts job
// timing and beat counts from the launch/done rules, and checks three sizings.
module tb_stream_run_sequencer;

    localparam int TMO_T = 16;

    logic        aclk = 1'b0;
    logic        areset;
    logic        ap_start;
    logic        gen_done;
    logic        s_mon_tvalid;
    logic        s_mon_tready;
    logic [15:0] num_runs;

    logic        m_ap_ready, m_ap_idle, m_ap_done, m_gen_start, m_err_timeout, m_err_spurious;
    logic [15:0] m_runs;
    logic [31:0] m_beats;

    logic        s_ap_ready_unused, s_ap_idle_unused, s_ap_done, s_gen_start_unused;
    logic        s_err_timeout_unused, s_err_spurious_unused;
    logic [3:0]  s_runs;
    logic [7:0]  s_beats;

    logic        t_ap_ready_unused, t_ap_idle, t_ap_done, t_gen_start, t_err_timeout;
    logic        t_err_spurious_unused;
    logic [15:0] t_runs;
    logic [31:0] t_beats_unused;

    int n_vec = 0;
    int n_err = 0;

    // Observations and model predictions filled in by run_job.
    int o_ready_cnt, o_launches, o_min_low, o_max_high, o_done_t, o_s_done_t;
    bit o_ready_t0, o_spur_t1;
    int exp_beats, exp_done_t;

    always #5 aclk = ~aclk;

    stream_run_sequencer #(
        .C_RUN_COUNT_WIDTH(16), .C_BEAT_COUNT_WIDTH(32), .C_TIMEOUT_CYCLES(4096)
    ) dut_m (
        .aclk(aclk), .areset(areset), .ap_start(ap_start), .ap_ready(m_ap_ready),
        .ap_idle(m_ap_idle), .ap_done(m_ap_done), .num_runs(num_runs),
        .gen_start(m_gen_start), .gen_done(gen_done), .s_mon_tvalid(s_mon_tvalid),
        .s_mon_tready(s_mon_tready), .runs_completed(m_runs), .beat_count(m_beats),
        .err_timeout(m_err_timeout), .err_spurious(m_err_spurious)
    );

    stream_run_sequencer #(
        .C_RUN_COUNT_WIDTH(4), .C_BEAT_COUNT_WIDTH(8), .C_TIMEOUT_CYCLES(0)
    ) dut_s (
        .aclk(aclk), .areset(areset), .ap_start(ap_start), .ap_ready(s_ap_ready_unused),
        .ap_idle(s_ap_idle_unused), .ap_done(s_ap_done), .num_runs(num_runs[3:0]),
        .gen_start(s_gen_start_unused), .gen_done(gen_done), .s_mon_tvalid(s_mon_tvalid),
        .s_mon_tready(s_mon_tready), .runs_completed(s_runs), .beat_count(s_beats),
        .err_timeout(s_err_timeout_unused), .err_spurious(s_err_spurious_unused)
    );

    stream_run_sequencer #(
        .C_RUN_COUNT_WIDTH(16), .C_BEAT_COUNT_WIDTH(32), .C_TIMEOUT_CYCLES(TMO_T)
    ) dut_t (
        .aclk(aclk), .areset(areset), .ap_start(ap_start), .ap_ready(t_ap_ready_unused),
        .ap_idle(t_ap_idle), .ap_done(t_ap_done), .num_runs(num_runs),
        .gen_start(t_gen_start), .gen_done(gen_done), .s_mon_tvalid(s_mon_tvalid),
        .s_mon_tready(s_mon_tready), .runs_completed(t_runs), .beat_count(t_beats_unused),
        .err_timeout(t_err_timeout), .err_spurious(t_err_spurious_unused)
    );

    task automatic do_reset();
        areset = 1'b1;
        ap_start = 1'b0;
        gen_done = 1'b0;
        s_mon_tvalid = 1'b0;
        s_mon_tready = 1'b0;
        num_runs = '0;
        repeat (3) @(posedge aclk);
        #1;
        areset = 1'b0;
    endtask

    // Host + generator model for one job; t = 0 is the accept cycle.
    // Beats count from the cycle after accept through the final gen_done cycle.
    task automatic run_job(input int nr, input int dly_min, input int dly_max,
                           input int stream_beats, input bit hold, input int budget);
        int dones, due, sent, cur_high, last_fall;
        bit pend, streaming, closed, prev_gs;
        o_ready_cnt = 0; o_ready_t0 = 0; o_launches = 0; o_min_low = 1 << 30;
        o_max_high = 0; o_done_t = -1; o_s_done_t = -1; o_spur_t1 = 1'b1;
        exp_beats = 0; exp_done_t = (nr == 0) ? 1 : -1;
        dones = 0; due = 0; sent = 0; cur_high = 0; last_fall = 0;
        pend = 0; streaming = 0; closed = (nr == 0); prev_gs = 0;
        for (int t = 0; t < budget; t++) begin
            @(posedge aclk);
            #1;
            ap_start = hold ? 1'b1 : (t == 0);
            num_runs = 16'(nr);
            gen_done = 1'b0;
            if (stream_beats > 0) begin
                s_mon_tvalid = streaming;
                s_mon_tready = (t % 2 == 1);
                if (streaming && s_mon_tready) begin
                    sent++;
                    if (sent == stream_beats) begin
                        gen_done = 1'b1;
                        streaming = 0;
                    end
                end
            end else begin
                s_mon_tvalid = 1'($urandom_range(0, 1));
                s_mon_tready = 1'($urandom_range(0, 1));
                if (pend && t == due) begin
                    gen_done = 1'b1;
                    pend = 0;
                end
            end
            if (gen_done) dones++;
            if (!closed && t >= 1 && s_mon_tvalid && s_mon_tready) exp_beats++;
            if (!closed && gen_done && dones == nr) begin
                closed = 1;
                exp_done_t = t + 1;
            end
            @(negedge aclk);
            if (m_ap_ready) begin
                o_ready_cnt++;
                if (t == 0) o_ready_t0 = 1;
            end
            if (t == 1) o_spur_t1 = m_err_spurious;
            if (m_gen_start) begin
                if (!prev_gs) begin
                    if (o_launches > 0 && (t - last_fall) < o_min_low) o_min_low = t - last_fall;
                    o_launches++;
                    cur_high = 0;
                    if (stream_beats > 0) begin
                        streaming = 1;
                        sent = 0;
                    end else begin
                        pend = 1;
                        due = t + int'($urandom_range(dly_min, dly_max));
                    end
                end
                cur_high++;
                if (cur_high > o_max_high) o_max_high = cur_high;
            end else if (prev_gs) begin
                last_fall = t;
            end
            prev_gs = m_gen_start;
            if (s_ap_done && o_s_done_t < 0) o_s_done_t = t;
            if (m_ap_done) begin
                o_done_t = t;
                break;
            end
        end
        if (o_done_t < 0) begin
            n_vec++; n_err++;
            $display("FAIL job_budget: no ap_done within %0d cycles (nr=%0d)", budget, nr);
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge aclk);
        n_vec++; if (m_ap_idle !== 1'b1) begin n_err++; $display("FAIL rst_idle: got %b want 1", m_ap_idle); end
        n_vec++; if (m_ap_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready: got %b want 0", m_ap_ready); end
        n_vec++; if (m_ap_done !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b want 0", m_ap_done); end
        n_vec++; if (m_gen_start !== 1'b0) begin n_err++; $display("FAIL rst_gen_start: got %b want 0", m_gen_start); end
        n_vec++; if (m_runs !== 16'd0) begin n_err++; $display("FAIL rst_runs: got %0d want 0", m_runs); end
        n_vec++; if (m_beats !== 32'd0) begin n_err++; $display("FAIL rst_beats: got %0d want 0", m_beats); end
        n_vec++; if ({m_err_timeout, m_err_spurious} !== 2'b00) begin n_err++; $display("FAIL rst_err: got %b want 00", {m_err_timeout, m_err_spurious}); end
        n_vec++; if (t_ap_idle !== 1'b1) begin n_err++; $display("FAIL rst_t_idle: got %b want 1", t_ap_idle); end
    endtask

    task automatic test_basic_three_runs();
        do_reset();
        run_job(3, 20, 20, 0, 1'b0, 500);
        n_vec++; if (o_ready_cnt != 1 || !o_ready_t0) begin n_err++; $display("FAIL basic_ready: got %0d pulses want 1 at accept", o_ready_cnt); end
        n_vec++; if (o_launches != 3) begin n_err++; $display("FAIL basic_launches: got %0d want 3", o_launches); end
        n_vec++; if (o_min_low < 1) begin n_err++; $display("FAIL basic_low_gap: got %0d want >=1", o_min_low); end
        n_vec++; if (o_max_high != 1) begin n_err++; $display("FAIL basic_start_width: got %0d want 1", o_max_high); end
        n_vec++; if (o_done_t != exp_done_t) begin n_err++; $display("FAIL basic_done_time: got %0d want %0d", o_done_t, exp_done_t); end
        n_vec++; if (m_runs !== 16'd3) begin n_err++; $display("FAIL basic_runs: got %0d want 3", m_runs); end
        n_vec++; if (m_beats !== 32'(exp_beats)) begin n_err++; $display("FAIL basic_beats: got %0d want %0d", m_beats, exp_beats); end
        @(posedge aclk);
        #1;
        ap_start = 1'b0;
        @(negedge aclk);
        n_vec++; if (m_ap_idle !== 1'b1 || m_ap_done !== 1'b0) begin n_err++; $display("FAIL basic_after_done: idle=%b done=%b want 1 0", m_ap_idle, m_ap_done); end
        n_vec++; if (m_runs !== 16'd3) begin n_err++; $display("FAIL basic_runs_hold: got %0d want 3", m_runs); end
    endtask

    task automatic test_zero_runs();
        run_job(0, 1, 1, 0, 1'b0, 10);
        n_vec++; if (o_ready_cnt != 1) begin n_err++; $display("FAIL zero_ready: got %0d want 1", o_ready_cnt); end
        n_vec++; if (o_done_t != 1) begin n_err++; $display("FAIL zero_done_time: got %0d want 1", o_done_t); end
        n_vec++; if (o_launches != 0) begin n_err++; $display("FAIL zero_launches: got %0d want 0", o_launches); end
        n_vec++; if (m_beats !== 32'd0) begin n_err++; $display("FAIL zero_beats: got %0d want 0", m_beats); end
    endtask

    task automatic test_timeout();
        int launch_t, done_t, rises;
        bit prev, err_at_done;
        logic [15:0] runs_at_done;
        do_reset();
        launch_t = -1; done_t = -1; rises = 0; prev = 0; err_at_done = 0; runs_at_done = '1;
        for (int t = 0; t < 60; t++) begin
            @(posedge aclk);
            #1;
            ap_start = (t == 0);
            num_runs = 16'd2;
            gen_done = 1'b0;
            s_mon_tvalid = 1'b0;
            s_mon_tready = 1'b0;
            @(negedge aclk);
            if (t_gen_start && !prev) begin
                rises++;
                if (launch_t < 0) launch_t = t;
            end
            prev = t_gen_start;
            if (t_ap_done && done_t < 0) begin
                done_t = t;
                err_at_done = t_err_timeout;
                runs_at_done = t_runs;
            end
        end
        n_vec++; if (launch_t != 1) begin n_err++; $display("FAIL tmo_launch_time: got %0d want 1", launch_t); end
        n_vec++; if (done_t != 1 + 1 + TMO_T) begin n_err++; $display("FAIL tmo_done_time: got %0d want %0d", done_t, 2 + TMO_T); end
        n_vec++; if (err_at_done !== 1'b1) begin n_err++; $display("FAIL tmo_err: got %b want 1", err_at_done); end
        n_vec++; if (runs_at_done !== 16'd0) begin n_err++; $display("FAIL tmo_runs: got %0d want 0", runs_at_done); end
        n_vec++; if (rises != 1) begin n_err++; $display("FAIL tmo_launches: got %0d want 1", rises); end
        n_vec++; if (t_err_timeout !== 1'b1) begin n_err++; $display("FAIL tmo_sticky: got %b want 1", t_err_timeout); end
        n_vec++; if (m_err_timeout !== 1'b0) begin n_err++; $display("FAIL tmo_long_wd: got %b want 0", m_err_timeout); end
    endtask

    // gen_done lands on the very cycle the watchdog expires.
    task automatic test_timeout_race();
        int done_t;
        bit err_at_done;
        logic [15:0] runs_at_done;
        do_reset();
        done_t = -1; err_at_done = 1; runs_at_done = '0;
        for (int t = 0; t < 30; t++) begin
            @(posedge aclk);
            #1;
            ap_start = (t == 0);
            num_runs = 16'd1;
            gen_done = (t == 1 + TMO_T);
            @(negedge aclk);
            if (t_ap_done && done_t < 0) begin
                done_t = t;
                err_at_done = t_err_timeout;
                runs_at_done = t_runs;
            end
        end
        n_vec++; if (done_t != 2 + TMO_T) begin n_err++; $display("FAIL race_done_time: got %0d want %0d", done_t, 2 + TMO_T); end
        n_vec++; if (err_at_done !== 1'b0) begin n_err++; $display("FAIL race_err: got %b want 0", err_at_done); end
        n_vec++; if (runs_at_done !== 16'd1) begin n_err++; $display("FAIL race_runs: got %0d want 1", runs_at_done); end
    endtask

    task automatic test_beat_stream();
        do_reset();
        run_job(1, 1, 1, 1024, 1'b0, 5000);
        n_vec++; if (m_beats !== 32'd1024) begin n_err++; $display("FAIL stream_1024: got %0d want 1024", m_beats); end
        n_vec++; if (m_beats !== 32'(exp_beats)) begin n_err++; $display("FAIL stream_model: got %0d want %0d", m_beats, exp_beats); end
        n_vec++; if (s_beats !== 8'd255) begin n_err++; $display("FAIL stream_sat_1024: got %0d want 255", s_beats); end
        run_job(1, 1, 1, 300, 1'b0, 2000);
        n_vec++; if (m_beats !== 32'd300) begin n_err++; $display("FAIL stream_300: got %0d want 300", m_beats); end
        n_vec++; if (s_beats !== 8'd255) begin n_err++; $display("FAIL stream_sat_300: got %0d want 255", s_beats); end
    endtask

    task automatic test_spurious();
        do_reset();
        @(posedge aclk);
        #1;
        gen_done = 1'b1;
        @(posedge aclk);
        #1;
        gen_done = 1'b0;
        @(negedge aclk);
        n_vec++; if (m_err_spurious !== 1'b1) begin n_err++; $display("FAIL spur_set: got %b want 1", m_err_spurious); end
        n_vec++; if (m_runs !== 16'd0) begin n_err++; $display("FAIL spur_no_count: got %0d want 0", m_runs); end
        run_job(1, 2, 6, 0, 1'b0, 100);
        n_vec++; if (o_spur_t1 !== 1'b0) begin n_err++; $display("FAIL spur_clear: got %b want 0", o_spur_t1); end
        n_vec++; if (m_runs !== 16'd1) begin n_err++; $display("FAIL spur_job_runs: got %0d want 1", m_runs); end
        n_vec++; if (m_err_spurious !== 1'b0) begin n_err++; $display("FAIL spur_end: got %b want 0", m_err_spurious); end
    endtask

    task automatic test_reset_mid_job();
        int launches, due, l2_t, dones_after;
        bit pend, prev, hit;
        do_reset();
        launches = 0; due = 0; l2_t = -1; pend = 0; prev = 0; hit = 0;
        for (int t = 0; t < 200 && !hit; t++) begin
            @(posedge aclk);
            #1;
            ap_start = (t == 0);
            num_runs = 16'd4;
            s_mon_tvalid = 1'b1;
            s_mon_tready = 1'b1;
            gen_done = pend && (t == due);
            if (gen_done) pend = 0;
            if (l2_t >= 0 && t == l2_t + 3) begin
                areset = 1'b1;
                hit = 1;
            end
            @(negedge aclk);
            if (m_gen_start && !prev) begin
                launches++;
                pend = 1;
                due = t + 8;
                if (launches == 2) l2_t = t;
            end
            prev = m_gen_start;
        end
        @(posedge aclk);
        #1;
        areset = 1'b0;
        ap_start = 1'b0;
        gen_done = 1'b0;
        @(negedge aclk);
        n_vec++; if (!hit) begin n_err++; $display("FAIL mid_reach_run2: got launches=%0d want 2", launches); end
        n_vec++; if ({m_ap_idle, m_ap_ready, m_ap_done, m_gen_start} !== 4'b1000) begin n_err++; $display("FAIL mid_ctrl: got %b want 1000", {m_ap_idle, m_ap_ready, m_ap_done, m_gen_start}); end
        n_vec++; if (m_runs !== 16'd0 || m_beats !== 32'd0) begin n_err++; $display("FAIL mid_counts: got runs=%0d beats=%0d want 0 0", m_runs, m_beats); end
        n_vec++; if ({m_err_timeout, m_err_spurious} !== 2'b00) begin n_err++; $display("FAIL mid_err: got %b want 00", {m_err_timeout, m_err_spurious}); end
        dones_after = 0;
        repeat (20) begin
            @(negedge aclk);
            if (m_ap_done) dones_after++;
        end
        n_vec++; if (dones_after != 0) begin n_err++; $display("FAIL mid_no_done: got %0d pulses want 0", dones_after); end
        run_job(2, 1, 5, 0, 1'b0, 100);
        n_vec++; if (o_launches != 2 || m_runs !== 16'd2) begin n_err++; $display("FAIL mid_restart: got launches=%0d runs=%0d want 2 2", o_launches, m_runs); end
    endtask

    task automatic test_all_ones();
        do_reset();
        run_job(15, 1, 3, 0, 1'b0, 400);
        n_vec++; if (s_runs !== 4'hF) begin n_err++; $display("FAIL ones_runs: got %0d want 15", s_runs); end
        n_vec++; if (o_s_done_t != exp_done_t) begin n_err++; $display("FAIL ones_done_time: got %0d want %0d", o_s_done_t, exp_done_t); end
        n_vec++; if (o_launches != 15) begin n_err++; $display("FAIL ones_launches: got %0d want 15", o_launches); end
    endtask

    task automatic test_back_to_back();
        int nr;
        do_reset();
        for (int j = 0; j < 3; j++) begin
            nr = int'($urandom_range(1, 4));
            run_job(nr, 1, 6, 0, (j < 2), 300);
            n_vec++; if (!o_ready_t0 || o_ready_cnt != 1) begin n_err++; $display("FAIL b2b_accept[%0d]: got t0=%b cnt=%0d want 1 1", j, o_ready_t0, o_ready_cnt); end
            n_vec++; if (o_done_t != exp_done_t || m_runs !== 16'(nr)) begin n_err++; $display("FAIL b2b_job[%0d]: done=%0d runs=%0d want %0d %0d", j, o_done_t, m_runs, exp_done_t, nr); end
            n_vec++; if (m_beats !== 32'(exp_beats)) begin n_err++; $display("FAIL b2b_beats[%0d]: got %0d want %0d", j, m_beats, exp_beats); end
        end
    endtask

    task automatic test_random_jobs();
        int nr, sat;
        do_reset();
        for (int j = 0; j < 8; j++) begin
            nr = int'($urandom_range(1, 6));
            run_job(nr, 1, 8, 0, 1'b0, 400);
            sat = (exp_beats > 255) ? 255 : exp_beats;
            n_vec++; if (o_launches != nr || o_min_low < 1 || o_max_high != 1) begin n_err++; $display("FAIL rnd_launch[%0d]: got n=%0d low=%0d high=%0d want %0d >=1 1", j, o_launches, o_min_low, o_max_high, nr); end
            n_vec++; if (o_done_t != exp_done_t) begin n_err++; $display("FAIL rnd_done_time[%0d]: got %0d want %0d", j, o_done_t, exp_done_t); end
            n_vec++; if (m_runs !== 16'(nr)) begin n_err++; $display("FAIL rnd_runs[%0d]: got %0d want %0d", j, m_runs, nr); end
            n_vec++; if (m_beats !== 32'(exp_beats)) begin n_err++; $display("FAIL rnd_beats[%0d]: got %0d want %0d", j, m_beats, exp_beats); end
            n_vec++; if (s_beats !== 8'(sat)) begin n_err++; $display("FAIL rnd_sat_beats[%0d]: got %0d want %0d", j, s_beats, sat); end
            n_vec++; if ({m_err_timeout, m_err_spurious} !== 2'b00) begin n_err++; $display("FAIL rnd_err[%0d]: got %b want 00", j, {m_err_timeout, m_err_spurious}); end
            repeat (int'($urandom_range(0, 3))) @(posedge aclk);
            #1;
            ap_start = 1'b0;
        end
    endtask

    initial begin
        areset = 1'b1;
        ap_start = 1'b0;
        gen_done = 1'b0;
        s_mon_tvalid = 1'b0;
        s_mon_tready = 1'b0;
        num_runs = '0;
        test_reset();
        test_basic_three_runs();
        test_zero_runs();
        test_timeout();
        test_timeout_race();
        test_beat_stream();
        test_spurious();
        test_reset_mid_job();
        test_all_ones();
        test_back_to_back();
        test_random_jobs();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/stream_run_sequencer.md
Name: stream_run_sequencer

Overview:
- Kernel-level control block that launches a stream number-generator datapath N times back-to-back for one host start, then reports completion.
- Sits between the host ap_ctrl_hs control signals and the generator's ap_start/ap_done pair.
- Monitors the generator's AXI4-Stream output to count beats, and runs a watchdog per run.

Parameters:
- C_RUN_COUNT_WIDTH, 16, width of num_runs and run counter.
- C_BEAT_COUNT_WIDTH, 32, width of total beat counter (saturating).
- C_TIMEOUT_CYCLES, 65536, max cycles in WAIT before abort; 0 disables watchdog.

Ports:
- aclk  in  1  clock.
- areset  in  1  synchronous active-high reset.
- ap_start  in  1  host start, level, held until ap_ready.
- ap_ready  out  1  one-cycle pulse: start accepted.
- ap_idle  out  1  high in IDLE only.
- ap_done  out  1  one-cycle pulse at end of job.
- num_runs  in  C_RUN_COUNT_WIDTH  generator runs per job, sampled on accept.
- gen_start  out  1  start to generator; generator launches on its rising edge.
- gen_done  in  1  generator completion (tready & tlast), may be single-cycle.
- s_mon_tvalid  in  1  monitored stream valid.
- s_mon_tready  in  1  monitored stream ready.
- runs_completed  out  C_RUN_COUNT_WIDTH  runs finished in current/last job.
- beat_count  out  C_BEAT_COUNT_WIDTH  beats (tvalid&tready) in current/last job, saturates at all-ones.
- err_timeout  out  1  sticky: a run hit the watchdog.
- err_spurious  out  1  sticky: gen_done seen outside WAIT.

Behaviour:
- Reset: state IDLE, ap_idle=1, ap_ready=0, ap_done=0, gen_start=0, runs_completed=0, beat_count=0, err_*=0. Reset mid-job aborts immediately; no ap_done.
- States: IDLE, LAUNCH, WAIT, GAP, DONE (encoding from package).
- IDLE: ap_idle=1. If ap_start=1: ap_ready pulses in the same cycle. Latch target=num_runs. Clear runs_completed, beat_count, err_*. Next state is LAUNCH, or DONE if num_runs==0.
- LAUNCH: gen_start=1 for exactly one cycle. Then WAIT; watchdog cleared.
- WAIT: gen_start=0; watchdog increments each cycle.
  - On gen_done: runs_completed+1. If new value==target, go to DONE, else go to GAP.
  - If watchdog reaches C_TIMEOUT_CYCLES-1 without gen_done (and C_TIMEOUT_CYCLES != 0): set err_timeout, go to DONE.
  - gen_done and timeout in the same cycle: gen_done wins; no error.
- GAP: gen_start=0 for one cycle, guaranteeing a low-to-high edge for the next launch. Then LAUNCH. Minimum launch-to-launch spacing: LAUNCH + >=1 WAIT + GAP.
- DONE: ap_done=1 for one cycle, then IDLE. runs_completed and beat_count hold until the next accept.
- ap_start in any state other than IDLE is ignored; host holding ap_start high after ap_done starts a new job on the IDLE cycle.
- gen_done in any state other than WAIT sets err_spurious; no count change.
- Beat counter:
  - Increments on s_mon_tvalid & s_mon_tready in LAUNCH/WAIT/GAP.
  - Saturates, no wrap.
  - A beat coinciding with the accept cycle is not counted.
- Run counter compare uses full C_RUN_COUNT_WIDTH; num_runs = all-ones is legal.
- All outputs are registered except ap_ready, ap_idle and ap_done, which are decoded from the state register (no input-to-output combinational path except ap_ready, which depends on ap_start).
- Latency: ap_start accept to gen_start = 1 cycle. Final gen_done to ap_done = 1 cycle.

Decomposition:
- Package stream_run_seq_pkg:
  - state enum typedef (IDLE, LAUNCH, WAIT, GAP, DONE).
  - Default width localparams.
- One sub-module: seq_sat_counter (parameterised width, clear, enable, saturate-at-max, terminal-compare output). Used for the beat counter, run counter and watchdog.
- FSM lives in the top.

Test Plan:
- Reset then num_runs=3, ap_start held; gen_done driven 20 cycles after each gen_start rise -> ap_ready once; exactly 3 gen_start rising edges, each separated by >=1 low cycle; ap_done one cycle after 3rd gen_done; runs_completed=3.
- num_runs=0, ap_start -> ap_ready then ap_done next cycle; gen_start never asserts; beat_count=0.
- C_TIMEOUT_CYCLES=16, num_runs=2, gen_done never driven -> err_timeout=1; ap_done 16 cycles after WAIT entry; runs_completed=0.
- num_runs=1; monitor stream 1024 beats with tready toggling every other cycle -> beat_count=1024. With C_BEAT_COUNT_WIDTH=8 and 300 beats -> beat_count=255.
- gen_done pulse while IDLE, then a normal 1-run job -> err_spurious=1 before the job. After accept, err_spurious clears to 0 and the job completes with runs_completed=1.
- areset asserted during WAIT of run 2 of 4 -> next cycle all outputs at reset values; no ap_done; new ap_start restarts from run 1.
